// File: rtl/cirno9_sram_rsp_pkg.sv
// cirno9_sram_rsp_pkg: shared constants for the cirno9 SRAM responder.
// Holds the FSM encodings and the address-window helper used by the
// optional range check (CIRNO_SRAM_RANGE_CHK_EN).
package cirno9_sram_rsp_pkg;

  // Responder FSM encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Width of the wait-cycle counter (WAIT ranges 0..15).
  localparam int CNT_W = 4;

  // True when a byte offset from BASE falls inside a 2^aw-word array.
  function automatic logic addr_in_range(input logic [31:0] off, input int aw);
    return (off >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/cirno9_sram_rsp_bank.sv
// cirno9_sram_bank: 2^AW x 32 word array with four byte-lane write enables
// and a registered read port. The read register is cleared by reset; the
// array itself is not.
module cirno9_sram_bank #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wdat_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rdat_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdat_q;

  // Byte-lane write: only enabled lanes change, the rest of the word is kept.
  // NOTE: the array has no reset branch so it can map onto an SRAM macro;
  // sequential state always uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wdat_i[8*b +: 8];
      end
    end
  end

  // Registered read port; holds its value until the next read completes.
  always_ff @(posedge clk) begin
    if (rst)          rdat_q <= '0;
    else if (rd_en_i) rdat_q <= rd_zero_i ? 32'h0 : mem_q[rd_idx_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/cirno9_sram_rsp.sv
// cirno9_sram_rsp: responder for the cirno9 core's SRAM request port.
// Accepts one read or byte-masked write, waits WAIT cycles, then pulses
// o_hs_ram4ls_rdy for one cycle. Define CIRNO_SRAM_RANGE_CHK_EN to flag and
// suppress accesses outside [BASE, BASE + 4*2^AW); otherwise addresses alias.
module cirno9_sram_rsp
  import cirno9_sram_rsp_pkg::*;
#(
  parameter int          AW   = 12,
  parameter int          WAIT = 1,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sram_ren,
  input  logic [3:0]  i_sram_wen,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic [31:0] o_sram_rdat,
  output logic        o_hs_ram4ls_rdy,
  output logic        o_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      adr_q, wdat_q;
  logic [3:0]       wen_q;
  logic             wr_q;

  logic             req;
  logic             go_resp;
  logic [31:0]      cur_adr;
  logic             cur_wr;
  logic [31:0]      off;
  logic [AW-1:0]    idx;
  logic             oor;
  logic             unused_bits;

  assign req = i_sram_ren | (|i_sram_wen);

  // In IDLE the live request drives the array (zero-wait reads); afterwards
  // the latched copy does, so a requester changing inputs cannot disturb it.
  assign cur_adr = (state_q == ST_IDLE) ? i_adr : adr_q;
  assign cur_wr  = (state_q == ST_IDLE) ? (|i_sram_wen) : wr_q;
  assign off     = cur_adr - BASE;
  assign idx     = off[AW+1:2];

`ifdef CIRNO_SRAM_RANGE_CHK_EN
  assign oor = !addr_in_range(off, AW);
`else
  assign oor = 1'b0;
`endif

  assign unused_bits = ^{off[1:0], off[31:AW+2]};

  // Next-state logic for the IDLE -> WAIT -> RESP handshake.
  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter and the request latched on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      wen_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        adr_q  <= i_adr;
        wdat_q <= i_wdat;
        wen_q  <= i_sram_wen;
        wr_q   <= |i_sram_wen;
      end
    end
  end

`ifdef CIRNO_SRAM_RANGE_CHK_EN
  logic err_q;

  // Out-of-range flag, raised only for the ready cycle.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= go_resp & oor;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // Write commits at the end of RESP unless reset aborts it; a read is
  // captured on the edge that enters RESP.
  cirno9_sram_bank #(.AW(AW)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we_i      ((state_q == ST_RESP) & wr_q & ~oor & ~rst),
    .be_i      (wen_q),
    .wr_idx_i  (idx),
    .wdat_i    (wdat_q),
    .rd_en_i   (go_resp & ~cur_wr),
    .rd_zero_i (oor),
    .rd_idx_i  (idx),
    .rdat_o    (o_sram_rdat)
  );

  assign o_hs_ram4ls_rdy = (state_q == ST_RESP);

endmodule
